ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
- Upstream stage of the keyboard matrix mapper.
- Receives raw PS/2 device-to-host frames and validates start, parity and stop bits.
- Assembles multi-byte Set-2 sequences (E0/F0/E1 prefixes) into single key events.
- Each event is one clk-wide strobe carrying {ext, release, code}; the mapper consumes it directly without tracking prefixes itself.

Parameters:
- FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required to accept a new filtered level.
- TIMEOUT_CYCLES, default 30000: clk cycles without a filtered falling edge that abort an in-progress frame (≈2 ms at 14.7456 MHz).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: reset, synchronous, active-high.
- ps2_clk, in, 1: raw PS/2 clock, asynchronous.
- ps2_data, in, 1: raw PS/2 data, asynchronous.
- byte_valid, out, 1: one-cycle strobe; byte_data holds a good frame.
- byte_data, out, 8: last good received byte.
- ev_valid, out, 1: one-cycle key event strobe.
- ev_code, out, 8: scancode with prefixes stripped.
- ev_ext, out, 1: event was E0-prefixed.
- ev_release, out, 1: event was F0-prefixed (key up).
- frame_error, out, 1: one-cycle strobe on parity, start, stop or timeout failure.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; prefix flags cleared; filtered clk=1; filtered data=1; counters 0. Reset asserted mid-frame discards the partial frame with no strobe.
- Input path: 2-FF synchronizer on each line. Filter counter resets whenever the synchronized sample equals the current filtered level; otherwise it counts. The filtered level flips when the count reaches FILTER_LEN-1. ps2_data is filtered the same way.
- Sampling: data is sampled on the filtered ps2_clk falling edge, i.e. the cycle the filtered level goes 1→0.
- Frame FSM:
  - IDLE: on an edge, data=0 → DATA with bitcnt=0; data=1 → ignore, stay IDLE, no error.
  - DATA: shift LSB first; after 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: accept only if data=1 and popcount(8 data bits + parity) is odd. Accept → byte_valid=1 in the cycle after the stop edge, then IDLE. Failure → frame_error=1 instead, then IDLE.
- Timeout: a counter runs in every non-IDLE state and clears on each filtered falling edge. Reaching TIMEOUT_CYCLES → frame_error=1, return to IDLE, clear prefix flags. Timeout and byte completion are mutually exclusive.
- Assembler: acts on each byte_valid; its outputs are registered one cycle after byte_valid.
  - skip_cnt>0: decrement. On reaching 0, emit ev code=0x77 ext=0 release=1.
  - E1: emit code=0x77 ext=0 release=0 immediately, load skip_cnt=7 (Pause has no break code; the release is synthesized).
  - E0: set ext_p. F0: set rel_p. No event for either.
  - Ext_p=1 and byte 0x12 or 0x59: fake shift; drop; clear both flags.
  - Ext_p=0, rel_p=0 and byte in {00,AA,EE,FA,FC,FE,FF}: device response; drop.
  - Any other byte: emit ev_code=byte, ev_ext=ext_p, ev_release=rel_p; clear both flags.
- ev_code, ev_ext and ev_release hold their values until the next event. Consumers use them only while ev_valid=1.
- A frame_error clears ext_p, rel_p and skip_cnt; a broken prefix never contaminates the next key.
- Minimum event spacing is one PS/2 frame (≈11 PS/2 clocks); the block has no backpressure and needs no buffering.

Decomposition:
- Shared package ps2_pkg holds:
  - prefix constants PS2_EXT=8'hE0, PS2_REL=8'hF0, PS2_PAUSE=8'hE1, PS2_PAUSE_CODE=8'h77;
  - the device-response byte list;
  - the frame FSM state enum {IDLE, DATA, PARITY, STOP}.
- The same Set-2 code constants are reused by the matrix mapper.
- One sub-module: ps2_line_filter (synchronizer + glitch filter + falling-edge detect), instantiated twice, for clock and data. The frame FSM and the assembler stay in the top module.

Test Plan:
- Frame 0x1A with correct odd parity (parity=0) and stop=1 → byte_valid with byte_data=0x1A; ev_valid with code=0x1A, ext=0, release=0.
- Sequence F0 1A → exactly one ev_valid: code=0x1A, release=1, ext=0. Sequence E0 F0 75 → one ev_valid: code=0x75, ext=1, release=1.
- Frame 0x1C with wrong parity bit → frame_error pulse, no byte_valid. Then E0, a bad frame, then 0x74 → ev ext=0 (prefix cleared by the error).
- Stop after 5 data bits, idle for TIMEOUT_CYCLES → frame_error pulse in IDLE. A following good 0x29 → ev code=0x29.
- Full Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly two events: 0x77 press after the first byte, 0x77 release after the last byte.
- 0xAA alone → no ev_valid. 3-cycle glitch on ps2_clk with FILTER_LEN=8 → no bit sampled. E0 12 → dropped. Reset asserted at data bit 4 → no strobes; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants and frame-state encoding, used by the receiver
// and by the downstream matrix mapper.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT          = 8'hE0;
   localparam logic [7:0] PS2_REL          = 8'hF0;
   localparam logic [7:0] PS2_PAUSE        = 8'hE1;
   localparam logic [7:0] PS2_PAUSE_CODE   = 8'h77;
   localparam logic [7:0] PS2_FAKE_SHIFT_L = 8'h12;
   localparam logic [7:0] PS2_FAKE_SHIFT_R = 8'h59;

   // Pause sends E1 14 77 E1 F0 14 F0 77; the seven bytes after the first E1 are swallowed.
   localparam logic [2:0] PS2_PAUSE_SKIP   = 3'd7;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

   // Device response bytes (BAT result, echo, ack, errors, resend).
   function automatic logic is_dev_response(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_dev_response = 1'b1;
         default:                                          is_dev_response = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer, run-length glitch filter and falling-edge strobe for one
// PS/2 line. The edge strobe is high in the first cycle the filtered level reads 0.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic line_raw,
   output logic level,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         level  <= 1'b1;
         cnt    <= '0;
         fall   <= 1'b0;
      end else begin
         sync_1 <= line_raw;
         sync_2 <= sync_1;
         fall   <= 1'b0;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync_2;
            cnt   <= '0;
            fall  <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver and Set-2 prefix assembler producing one
// strobed key event per make/break sequence.
//
// state  | meaning
// IDLE   | waiting for a falling edge with data low (start bit)
// DATA   | shifting 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then strobing byte or error
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 30000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_release,
   output logic       frame_error
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic clk_lvl_unused;
   logic clk_fall;
   logic data_lvl;
   logic data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk      (clk),
      .reset    (reset),
      .line_raw (ps2_clk),
      .level    (clk_lvl_unused),
      .fall     (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk      (clk),
      .reset    (reset),
      .line_raw (ps2_data),
      .level    (data_lvl),
      .fall     (data_fall_unused)
   );

   frame_state_e  state, state_nxt;
   logic [2:0]    bitcnt, bitcnt_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          par_bit, par_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt;
   logic          byte_ok_nxt;
   logic          err_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bitcnt      <= '0;
         shreg       <= '0;
         par_bit     <= 1'b0;
         tmo_cnt     <= '0;
         byte_valid  <= 1'b0;
         byte_data   <= '0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_nxt;
         bitcnt      <= bitcnt_nxt;
         shreg       <= shreg_nxt;
         par_bit     <= par_nxt;
         tmo_cnt     <= tmo_nxt;
         byte_valid  <= byte_ok_nxt;
         frame_error <= err_nxt;
         if (byte_ok_nxt) byte_data <= shreg;
      end
   end

   always_comb begin
      state_nxt   = state;
      bitcnt_nxt  = bitcnt;
      shreg_nxt   = shreg;
      par_nxt     = par_bit;
      tmo_nxt     = tmo_cnt;
      byte_ok_nxt = 1'b0;
      err_nxt     = 1'b0;
      if (clk_fall) begin
         tmo_nxt = TMO_LOAD;
         case (state)
            IDLE: begin
               if (!data_lvl) begin
                  state_nxt  = DATA;
                  bitcnt_nxt = '0;
               end
            end
            DATA: begin
               shreg_nxt  = {data_lvl, shreg[7:1]};
               bitcnt_nxt = bitcnt + 1'b1;
               if (bitcnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: begin
               par_nxt   = data_lvl;
               state_nxt = STOP;
            end
            STOP: begin
               if (data_lvl && ^{shreg, par_bit}) byte_ok_nxt = 1'b1;
               else                                err_nxt     = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (state == IDLE) begin
         tmo_nxt = TMO_LOAD;
      end else if (tmo_cnt == '0) begin
         // A stalled frame is abandoned; a real edge on this cycle takes priority.
         err_nxt   = 1'b1;
         state_nxt = IDLE;
         tmo_nxt   = TMO_LOAD;
      end else begin
         tmo_nxt = tmo_cnt - 1'b1;
      end
   end

   logic       ext_p, ext_p_nxt;
   logic       rel_p, rel_p_nxt;
   logic [2:0] skip_cnt, skip_nxt;
   logic       ev_fire;
   logic [7:0] ev_code_nxt;
   logic       ev_ext_nxt;
   logic       ev_rel_nxt;

   always_comb begin
      ext_p_nxt   = ext_p;
      rel_p_nxt   = rel_p;
      skip_nxt    = skip_cnt;
      ev_fire     = 1'b0;
      ev_code_nxt = ev_code;
      ev_ext_nxt  = ev_ext;
      ev_rel_nxt  = ev_release;
      if (frame_error) begin
         ext_p_nxt = 1'b0;
         rel_p_nxt = 1'b0;
         skip_nxt  = '0;
      end else if (byte_valid) begin
         if (skip_cnt != '0) begin
            skip_nxt = skip_cnt - 1'b1;
            if (skip_cnt == 3'd1) begin
               ev_fire     = 1'b1;
               ev_code_nxt = PS2_PAUSE_CODE;
               ev_ext_nxt  = 1'b0;
               ev_rel_nxt  = 1'b1;
            end
         end else if (byte_data == PS2_PAUSE) begin
            ev_fire     = 1'b1;
            ev_code_nxt = PS2_PAUSE_CODE;
            ev_ext_nxt  = 1'b0;
            ev_rel_nxt  = 1'b0;
            skip_nxt    = PS2_PAUSE_SKIP;
         end else if (byte_data == PS2_EXT) begin
            ext_p_nxt = 1'b1;
         end else if (byte_data == PS2_REL) begin
            rel_p_nxt = 1'b1;
         end else if (ext_p && (byte_data == PS2_FAKE_SHIFT_L ||
                                byte_data == PS2_FAKE_SHIFT_R)) begin
            ext_p_nxt = 1'b0;
            rel_p_nxt = 1'b0;
         end else if (!ext_p && !rel_p && is_dev_response(byte_data)) begin
            ext_p_nxt = ext_p;
         end else begin
            ev_fire     = 1'b1;
            ev_code_nxt = byte_data;
            ev_ext_nxt  = ext_p;
            ev_rel_nxt  = rel_p;
            ext_p_nxt   = 1'b0;
            rel_p_nxt   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ext_p      <= 1'b0;
         rel_p      <= 1'b0;
         skip_cnt   <= '0;
         ev_valid   <= 1'b0;
         ev_code    <= '0;
         ev_ext     <= 1'b0;
         ev_release <= 1'b0;
      end else begin
         ext_p      <= ext_p_nxt;
         rel_p      <= rel_p_nxt;
         skip_cnt   <= skip_nxt;
         ev_valid   <= ev_fire;
         ev_code    <= ev_code_nxt;
         ev_ext     <= ev_ext_nxt;
         ev_release <= ev_rel_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: drives PS/2 frames, predicts the ordered strobe
// stream with a sequence-level model and checks every strobe against it.
module tb_ps2_scancode_rx;

   localparam int FL  = 8;
   localparam int TO  = 600;
   localparam int H   = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_release;
   logic       frame_error;

   ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .ev_valid    (ev_valid),
      .ev_code     (ev_code),
      .ev_ext      (ev_ext),
      .ev_release  (ev_release),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;   // 0 byte, 1 error, 2 event
      logic [7:0] data;
      logic       ext;
      logic       rel;
   } exp_t;

   exp_t        exp_q[$];
   logic [9:0]  ev_log[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic        prev_bv = 1'b0;

   bit m_ext = 0;
   bit m_rel = 0;
   int m_skip = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_resp(input logic [7:0] b);
      return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
             b == 8'hFC || b == 8'hFE || b == 8'hFF;
   endfunction

   function automatic void push_ev(input logic [7:0] c, input bit x, input bit r);
      exp_t e;
      e.kind = 2; e.data = c; e.ext = x; e.rel = r;
      exp_q.push_back(e);
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      exp_t e;
      e.kind = 0; e.data = b; e.ext = 0; e.rel = 0;
      exp_q.push_back(e);
      if (m_skip > 0) begin
         m_skip--;
         if (m_skip == 0) push_ev(8'h77, 0, 1);
      end else if (b == 8'hE1) begin
         push_ev(8'h77, 0, 0);
         m_skip = 7;
      end else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
         m_ext = 0; m_rel = 0;
      end else if (!m_ext && !m_rel && is_resp(b)) begin
      end else begin
         push_ev(b, m_ext, m_rel);
         m_ext = 0; m_rel = 0;
      end
   endfunction

   function automatic void model_error();
      exp_t e;
      e.kind = 1; e.data = 0; e.ext = 0; e.rel = 0;
      exp_q.push_back(e);
      m_ext = 0; m_rel = 0; m_skip = 0;
   endfunction

   // Strobe checker: every strobe must match the head of the predicted stream.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (byte_valid) begin
            if (exp_q.size() == 0) check("spurious_byte", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("byte_kind", 0, e.kind);
               check("byte_data", byte_data, e.data);
            end
         end
         if (frame_error) begin
            if (exp_q.size() == 0) check("spurious_error", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("error_kind", 1, e.kind);
            end
         end
         if (ev_valid) begin
            ev_log.push_back({ev_ext, ev_release, ev_code});
            check("ev_after_byte", prev_bv, 1);
            if (exp_q.size() == 0) check("spurious_event", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("ev_kind", 2, e.kind);
               check("ev_code", ev_code, e.data);
               check("ev_flags", {ev_ext, ev_release}, {e.ext, e.rel});
            end
         end
      end
      prev_bv = byte_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic put_bit(input bit d, input bit glitch);
      ps2_data = d;
      if (glitch) begin
         tick(4);
         ps2_clk = 0;
         tick(3);
         ps2_clk = 1;
         tick(H - 7);
      end else tick(H);
      ps2_clk = 0;
      tick(H);
      ps2_clk = 1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      check(name, exp_q.size(), 0);
      exp_q.delete();
      tick(2 * H);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit glitch);
      bit par;
      par = ~(^b) ^ bad_par;
      if (bad_par || bad_stop) model_error();
      else model_byte(b);
      put_bit(0, 0);
      for (int i = 0; i < 8; i++) put_bit(b[i], glitch && i == 3);
      put_bit(par, 0);
      put_bit(!bad_stop, 0);
      ps2_data = 1;
      drain("drain");
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, 0, 0, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      @(negedge clk);
      check(name, {byte_valid, byte_data, ev_valid, ev_code, ev_ext, ev_release, frame_error}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rb;
      int r;
      tick(4);
      check_reset_outputs("reset_outputs");
      @(posedge clk);
      reset = 0;
      tick(20);

      // Plain make code
      ev_log.delete();
      good(8'h1A);
      check("make_1A_count", ev_log.size(), 1);
      if (ev_log.size() == 1) check("make_1A", ev_log[0], 10'h01A);
      check("byte_data_hold", byte_data, 8'h1A);

      ev_log.delete();
      good(8'hF0); good(8'h1A);
      check("break_1A_count", ev_log.size(), 1);
      if (ev_log.size() == 1) check("break_1A", ev_log[0], 10'h11A);

      ev_log.delete();
      good(8'hE0); good(8'hF0); good(8'h75);
      check("ext_break_count", ev_log.size(), 1);
      if (ev_log.size() == 1) check("ext_break_75", ev_log[0], 10'h375);

      // Parity and stop failures, prefix cleared by the error
      send_frame(8'h1C, 1, 0, 0);
      ev_log.delete();
      good(8'hE0); send_frame(8'h33, 0, 1, 0); good(8'h74);
      check("after_err_count", ev_log.size(), 1);
      if (ev_log.size() == 1) check("after_err_74", ev_log[0], 10'h074);

      // Timeout after 5 data bits
      model_error();
      put_bit(0, 0);
      for (int i = 0; i < 5; i++) put_bit(i[0], 0);
      ps2_data = 1;
      tick(TO - 50);
      check("timeout_not_early", exp_q.size(), 1);
      drain("timeout_drain");
      ev_log.delete();
      good(8'h29);
      check("after_tmo_count", ev_log.size(), 1);
      if (ev_log.size() == 1) check("after_tmo_29", ev_log[0], 10'h029);

      // Pause sequence
      ev_log.delete();
      good(8'hE1);
      check("pause_press_early", ev_log.size(), 1);
      good(8'h14); good(8'h77); good(8'hE1); good(8'hF0); good(8'h14); good(8'hF0);
      check("pause_no_mid_event", ev_log.size(), 1);
      good(8'h77);
      check("pause_count", ev_log.size(), 2);
      if (ev_log.size() == 2) begin
         check("pause_press", ev_log[0], 10'h077);
         check("pause_release", ev_log[1], 10'h177);
      end

      // Device response, glitch, fake shift
      ev_log.delete();
      good(8'hAA);
      check("resp_AA_none", ev_log.size(), 0);
      send_frame(8'h35, 0, 0, 1);
      check("glitch_35", ev_log.size() == 1 ? ev_log[0] : 10'h3FF, 10'h035);
      ev_log.delete();
      good(8'hE0); good(8'h12);
      check("fake_shift_none", ev_log.size(), 0);

      // Reset during data bit 4
      put_bit(0, 0);
      for (int i = 0; i < 4; i++) put_bit(1, 0);
      ps2_data = 0;
      tick(4);
      reset = 1;
      tick(3);
      check_reset_outputs("midframe_reset_outputs");
      ps2_clk = 1; ps2_data = 1;
      tick(20);
      reset = 0;
      m_ext = 0; m_rel = 0; m_skip = 0;
      tick(20);
      ev_log.delete();
      good(8'h4B);
      check("after_reset_4B", ev_log.size() == 1 ? ev_log[0] : 10'h3FF, 10'h04B);

      // Randomized traffic
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 15);
         rb = 8'($urandom);
         case (r)
            0: send_frame(8'hE0, 0, 0, 0);
            1: send_frame(8'hF0, 0, 0, 0);
            2: send_frame(8'hE1, 0, 0, 0);
            3: send_frame(rb[0] ? 8'hFA : 8'hAA, 0, 0, 0);
            4: send_frame(rb[0] ? 8'h12 : 8'h59, 0, 0, 0);
            5: send_frame(rb, 1, 0, 0);
            6: send_frame(rb, 0, 1, 0);
            7: send_frame(rb, 0, 0, 1);
            default: send_frame(rb, 0, 0, 0);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
